// File: rtl/lif_layer.sv
// Layer of leaky integrate-and-fire neurons: per timestep, serially accumulates
// the weights of the active input spikes, then applies fire/leak/refractory rules.
module lif_layer #(
    parameter int unsigned NUM_INPUTS = 4,
    parameter int unsigned NUM_NODES  = 4,
    parameter int unsigned W_WIDTH    = 8,
    parameter int unsigned V_WIDTH    = 16,
    parameter int          THRESHOLD  = 100,
    parameter int unsigned LEAK_SHIFT = 2,
    parameter int unsigned REFRACT    = 2,
    localparam int unsigned IW = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1,
    localparam int unsigned NW = (NUM_NODES > 1) ? $clog2(NUM_NODES) : 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  w_we_i,
    input  logic [IW-1:0]         w_in_i,
    input  logic [NW-1:0]         w_node_i,
    input  logic [W_WIDTH-1:0]    w_data_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [NUM_INPUTS-1:0] in_spikes_i,
    output logic                  out_valid_o,
    output logic [NUM_NODES-1:0]  nodes_o
);

    localparam int unsigned RW = (REFRACT > 0) ? $clog2(REFRACT + 1) : 1;
    localparam logic signed [V_WIDTH-1:0] V_MAX = {1'b0, {(V_WIDTH - 1){1'b1}}};
    localparam logic signed [V_WIDTH-1:0] V_MIN = {1'b1, {(V_WIDTH - 1){1'b0}}};
    localparam logic signed [V_WIDTH-1:0] V_TH  = V_WIDTH'(THRESHOLD);
    localparam logic [RW-1:0]             REF_INIT = RW'(REFRACT);
    localparam logic [IW-1:0]             IDX_LAST = IW'(NUM_INPUTS - 1);

    typedef enum logic [1:0] {IDLE, ACCUM, FIRE, OUT} state_e;

    state_e                     state_q, state_d;
    logic [IW-1:0]              idx_q, idx_d;
    logic [NUM_INPUTS-1:0]      spikes_q, spikes_d;
    logic signed [V_WIDTH-1:0]  v_q [NUM_NODES];
    logic signed [V_WIDTH-1:0]  v_d [NUM_NODES];
    logic [RW-1:0]              ref_q [NUM_NODES];
    logic [RW-1:0]              ref_d [NUM_NODES];
    logic signed [W_WIDTH-1:0]  w_q [NUM_INPUTS][NUM_NODES];
    logic signed [W_WIDTH-1:0]  w_d [NUM_INPUTS][NUM_NODES];
    logic                       out_valid_q, out_valid_d;
    logic [NUM_NODES-1:0]       nodes_q, nodes_d;

    // Add at one extra bit, then clamp to the representable range.
    function automatic logic signed [V_WIDTH-1:0] sat_add(
        input logic signed [V_WIDTH-1:0] v,
        input logic signed [W_WIDTH-1:0] w
    );
        logic signed [V_WIDTH:0] sum;
        sum = $signed({v[V_WIDTH-1], v}) +
              $signed({{(V_WIDTH + 1 - W_WIDTH){w[W_WIDTH-1]}}, w});
        if (sum[V_WIDTH] != sum[V_WIDTH-1]) begin
            return sum[V_WIDTH] ? V_MIN : V_MAX;
        end
        return sum[V_WIDTH-1:0];
    endfunction

    assign in_ready_o  = (state_q == IDLE) && rst_ni;
    assign out_valid_o = out_valid_q;
    assign nodes_o     = nodes_q;

    // Weight store: writes land at the edge, so a same-cycle ACCUM read sees the old value.
    always_comb begin
        w_d = w_q;
        if (w_we_i && (32'(w_in_i) < NUM_INPUTS) && (32'(w_node_i) < NUM_NODES)) begin
            w_d[w_in_i][w_node_i] = w_data_i;
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        spikes_d    = spikes_q;
        v_d         = v_q;
        ref_d       = ref_q;
        out_valid_d = 1'b0;
        nodes_d     = '0;
        case (state_q)
            IDLE: begin
                if (in_valid_i && in_ready_o) begin
                    spikes_d = in_spikes_i;
                    idx_d    = '0;
                    state_d  = ACCUM;
                end
            end
            ACCUM: begin
                if (spikes_q[idx_q]) begin
                    for (int n = 0; n < NUM_NODES; n++) begin
                        if (ref_q[n] == '0) begin
                            v_d[n] = sat_add(v_q[n], w_q[idx_q][n]);
                        end
                    end
                end
                if (idx_q == IDX_LAST) begin
                    state_d = FIRE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            FIRE: begin
                for (int n = 0; n < NUM_NODES; n++) begin
                    if (ref_q[n] != '0) begin
                        ref_d[n] = ref_q[n] - 1'b1;
                        v_d[n]   = '0;
                    end else if (v_q[n] >= V_TH) begin
                        nodes_d[n] = 1'b1;
                        v_d[n]     = '0;
                        ref_d[n]   = REF_INIT;
                    end else begin
                        v_d[n] = v_q[n] - (v_q[n] >>> LEAK_SHIFT);
                    end
                end
                out_valid_d = 1'b1;
                state_d     = OUT;
            end
            OUT: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            spikes_q    <= '0;
            out_valid_q <= 1'b0;
            nodes_q     <= '0;
            for (int n = 0; n < NUM_NODES; n++) begin
                v_q[n]   <= '0;
                ref_q[n] <= '0;
            end
            for (int i = 0; i < NUM_INPUTS; i++) begin
                for (int n = 0; n < NUM_NODES; n++) begin
                    w_q[i][n] <= '0;
                end
            end
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            spikes_q    <= spikes_d;
            out_valid_q <= out_valid_d;
            nodes_q     <= nodes_d;
            v_q         <= v_d;
            ref_q       <= ref_d;
            w_q         <= w_d;
        end
    end

endmodule

// File: tb/tb_lif_layer.sv
// Scoreboard bench for lif_layer: an integer timestep model predicts each output
// spike vector and its cycle; a monitor checks every out_valid pulse.
module tb_lif_layer;

    localparam int unsigned NI = 4;
    localparam int unsigned NN = 4;
    localparam int unsigned WW = 8;
    localparam int unsigned VW = 8;
    localparam int          TH = 100;
    localparam int unsigned LS = 2;
    localparam int unsigned RF = 2;
    localparam int VMAX = (1 <<< (VW - 1)) - 1;
    localparam int VMIN = -(1 <<< (VW - 1));

    logic          clk = 1'b0;
    logic          rst_n;
    logic          w_we;
    logic [1:0]    w_in;
    logic [1:0]    w_node;
    logic [WW-1:0] w_data;
    logic          in_valid;
    logic          in_ready;
    logic [NI-1:0] in_spikes;
    logic          out_valid;
    logic [NN-1:0] nodes;

    lif_layer #(
        .NUM_INPUTS(NI), .NUM_NODES(NN), .W_WIDTH(WW), .V_WIDTH(VW),
        .THRESHOLD(TH), .LEAK_SHIFT(LS), .REFRACT(RF)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .w_we_i(w_we), .w_in_i(w_in),
        .w_node_i(w_node), .w_data_i(w_data), .in_valid_i(in_valid),
        .in_ready_o(in_ready), .in_spikes_i(in_spikes),
        .out_valid_o(out_valid), .nodes_o(nodes)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NN-1:0] nodes;
        int            cyc;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   mv [NN];
    int   mref [NN];
    int   mw [NI][NN];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    // Reference model: whole timestep in plain integer arithmetic.
    function automatic int floor_div(input int a, input int b);
        int q;
        q = a / b;
        if ((a % b != 0) && (a < 0)) q = q - 1;
        return q;
    endfunction

    function automatic int clamp(input int x);
        if (x > VMAX) return VMAX;
        if (x < VMIN) return VMIN;
        return x;
    endfunction

    function automatic void model_reset();
        for (int n = 0; n < NN; n++) begin
            mv[n] = 0;
            mref[n] = 0;
            for (int i = 0; i < NI; i++) mw[i][n] = 0;
        end
    endfunction

    function automatic logic [NN-1:0] model_step(input logic [NI-1:0] spk);
        logic [NN-1:0] r = '0;
        for (int n = 0; n < NN; n++) begin
            if (mref[n] == 0) begin
                for (int i = 0; i < NI; i++) begin
                    if (spk[i]) mv[n] = clamp(mv[n] + mw[i][n]);
                end
            end
            if (mref[n] > 0) begin
                mref[n] = mref[n] - 1;
                mv[n] = 0;
            end else if (mv[n] >= TH) begin
                r[n] = 1'b1;
                mv[n] = 0;
                mref[n] = int'(RF);
            end else begin
                mv[n] = mv[n] - floor_div(mv[n], 1 << LS);
            end
        end
        return r;
    endfunction

    task automatic push_exp(input logic [NI-1:0] spk);
        exp_t e;
        e.nodes = model_step(spk);
        e.cyc = cyc + int'(NI) + 2;
        sb_q.push_back(e);
    endtask

    // Monitor: pops one expectation per out_valid pulse; nodes must be quiet otherwise.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (out_valid) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_out_valid", 1, 0);
                end else begin
                    e = sb_q.pop_front();
                    chk("nodes", int'(nodes), int'(e.nodes));
                    chk("out_cycle", cyc, e.cyc);
                end
            end else begin
                chk("nodes_quiet", int'(nodes), 0);
            end
        end
    end

    task automatic drain();
        int n = 0;
        while (sb_q.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("drain", sb_q.size(), 0);
    endtask

    task automatic wr(input int i, input int n, input int d);
        drain();
        @(negedge clk);
        w_we = 1'b1;
        w_in = 2'(i);
        w_node = 2'(n);
        w_data = WW'(d);
        @(negedge clk);
        w_we = 1'b0;
        mw[i][n] = d;
    endtask

    task automatic step(input logic [NI-1:0] spk);
        int n = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_spikes = spk;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("accept", int'(in_ready), 1);
        if (in_ready) push_exp(spk);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_spikes = NI'($urandom);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int last;
        int nacc;
        int nlow;
        logic [NI-1:0] spk;
        rst_n = 1'b0;
        w_we = 1'b0;
        w_in = '0;
        w_node = '0;
        w_data = '0;
        in_valid = 1'b0;
        in_spikes = '0;
        model_reset();
        repeat (3) begin
            @(negedge clk);
            chk("rst_in_ready", int'(in_ready), 0);
            chk("rst_out_valid", int'(out_valid), 0);
            chk("rst_nodes", int'(nodes), 0);
        end

        // First edge after reset release accepts; zero weights give no spikes.
        @(negedge clk);
        rst_n = 1'b1;
        in_valid = 1'b1;
        in_spikes = 4'hF;
        #1;
        chk("first_accept_ready", int'(in_ready), 1);
        push_exp(4'hF);
        @(posedge clk);
        #1;
        in_valid = 1'b0;

        // Fire then refractory pattern on node 0.
        wr(0, 0, 60);
        wr(1, 0, 50);
        repeat (4) step(4'b0011);

        // Leak on node 1.
        wr(0, 1, 40);
        repeat (2) step(4'b0001);

        // Negative saturation on node 2.
        for (int i = 0; i < NI; i++) wr(i, 2, -128);
        step(4'b1111);
        step(4'b0000);

        // Continuous in_valid: one acceptance every NI+3 cycles.
        drain();
        @(negedge clk);
        in_valid = 1'b1;
        last = -1;
        nacc = 0;
        nlow = 0;
        for (int k = 0; k < 28; k++) begin
            spk = NI'($urandom);
            in_spikes = spk;
            #1;
            if (in_ready) begin
                push_exp(spk);
                if (last >= 0) chk("accept_period", cyc - last, int'(NI) + 3);
                last = cyc;
                nacc++;
            end else begin
                nlow++;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        chk("accept_count", nacc, 4);
        chk("ready_low_count", nlow, 24);

        // Random weights and spike vectors.
        for (int t = 0; t < 40; t++) begin
            if ($urandom_range(0, 2) == 0) begin
                repeat ($urandom_range(1, 3))
                    wr(int'($urandom_range(0, NI - 1)), int'($urandom_range(0, NN - 1)),
                       int'($urandom_range(0, 170)) - 60);
            end
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 4)) @(negedge clk);
            step(NI'($urandom));
        end

        // Build up potentials, then reset in the second ACCUM cycle.
        for (int n = 0; n < NN; n++) wr(1, n, 30);
        repeat (3) step(4'b0010);
        step(4'b0010);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        sb_q.delete(sb_q.size() - 1);
        model_reset();
        repeat (2) begin
            #1;
            chk("abort_in_ready", int'(in_ready), 0);
            chk("abort_out_valid", int'(out_valid), 0);
            chk("abort_nodes", int'(nodes), 0);
            @(negedge clk);
        end
        rst_n = 1'b1;
        step(4'b1111);
        for (int n = 0; n < NN; n++) wr(0, n, 50);
        step(4'b0001);
        step(4'b0010);
        step(4'b0010);

        drain();
        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
